core_run_ctrl: RTL and testbench

Run-control sequencer for the single-cycle RV32I core. It replaces the free-running divided clock with one system clock plus a one-cycle commit enable. A programmable tick counter generates the commit rate, and the block implements run, halt, single-step and a single PC breakpoint. It sits between the board clock/buttons and the core's PC register, regfile write port and LSU write port, all of which qualify their updates with `o_core_en`.

---
 rtl/core_run_ctrl_if.sv | 34 +++
 rtl/core_run_ctrl.sv | 126 ++++++++++++
 tb/tb_core_run_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_run_ctrl_if.sv
// core_run_ctrl_if
//   Debug/run-control bundle between the board-side request logic and the
//   core run-control sequencer.
//   Requests (master -> slave): i_run_req, i_halt_req, i_step_req,
//     i_bp_en, i_bp_addr[31:0], i_pc[31:0], i_insn_vld
//   Status (slave -> master):   o_core_en, o_state[1:0], o_halted,
//     o_bp_hit, o_retired_cnt[31:0]
//   Signal names follow the core's i_/o_ naming as seen from the sequencer.
interface core_run_ctrl_if;
  logic        i_run_req;
  logic        i_halt_req;
  logic        i_step_req;
  logic        i_bp_en;
  logic [31:0] i_bp_addr;
  logic [31:0] i_pc;
  logic        i_insn_vld;
  logic        o_core_en;
  logic [1:0]  o_state;
  logic        o_halted;
  logic        o_bp_hit;
  logic [31:0] o_retired_cnt;

  modport master (
    output i_run_req, i_halt_req, i_step_req, i_bp_en, i_bp_addr, i_pc,
           i_insn_vld,
    input  o_core_en, o_state, o_halted, o_bp_hit, o_retired_cnt
  );

  modport slave (
    input  i_run_req, i_halt_req, i_step_req, i_bp_en, i_bp_addr, i_pc,
           i_insn_vld,
    output o_core_en, o_state, o_halted, o_bp_hit, o_retired_cnt
  );
endinterface

// File: rtl/core_run_ctrl.sv
// core_run_ctrl
//   Run-control sequencer for the single-cycle RV32I core. Produces a one-cycle
//   commit enable (o_core_en) every DIV_CNT system clocks and implements run,
//   halt, single-step and a single PC breakpoint.
//   Parameters: DIV_CNT      - clocks per commit tick (1 .. 2^32-1)
//               RUN_ON_RESET - 1: RUN after reset, 0: HALT after reset
//   Ports: i_clk   - system clock (rising edge)
//          i_reset - asynchronous active-high reset
//          bus     - core_run_ctrl_if.slave (requests, breakpoint, PC in;
//                    commit enable, state, halted, bp_hit, retired count out)
//   Build option: define CORE_RUN_CTRL_RETIRE_CNT_EN to build the 32-bit
//   retired-instruction counter; otherwise o_retired_cnt is tied to zero.
module core_run_ctrl #(
  parameter logic [31:0] DIV_CNT      = 32'd5_000_000,
  parameter bit          RUN_ON_RESET = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_reset,
  core_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  localparam logic [31:0] TICK_LAST   = DIV_CNT - 32'd1;
  localparam state_t      RESET_STATE = RUN_ON_RESET ? ST_RUN : ST_HALT;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] tick_cnt;
  logic        tick;
  logic        bp_match;
  logic        bp_skip;
  logic        bp_hit;
  logic        halted;
  logic        core_en;
  logic        resume;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                tick_cnt <= 32'd0;
    else if (tick_cnt == TICK_LAST) tick_cnt <= 32'd0;
    else                        tick_cnt <= tick_cnt + 32'd1;
  end

  assign tick = (tick_cnt == TICK_LAST);

  // bp_skip masks the compare right after a resume so the instruction at the
  // breakpoint PC is executed once instead of trapping again.
  assign bp_match = bus.i_bp_en && (bus.i_pc[31:2] == bus.i_bp_addr[31:2]) && !bp_skip;

  // Reset gating matters when DIV_CNT=1: tick is then 1 even during reset.
  assign core_en = !i_reset && tick &&
                   (((state == ST_RUN) && !bp_match) || (state == ST_STEP));

  always_comb begin
    state_nxt = state;
    resume    = 1'b0;
    case (state)
      ST_HALT, ST_BREAK: begin
        if (bus.i_halt_req) begin
          state_nxt = state;
        end else if (bus.i_step_req) begin
          state_nxt = ST_STEP;
          resume    = 1'b1;
        end else if (bus.i_run_req) begin
          state_nxt = ST_RUN;
          resume    = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.i_halt_req)        state_nxt = ST_HALT;
        else if (tick && bp_match) state_nxt = ST_BREAK;
      end
      ST_STEP: begin
        // The tick edge commits and halts together; an earlier halt aborts.
        if (bus.i_halt_req || tick) state_nxt = ST_HALT;
      end
      default: state_nxt = ST_HALT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= RESET_STATE;
      halted  <= !RUN_ON_RESET;
      bp_hit  <= 1'b0;
      bp_skip <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= (state_nxt == ST_HALT) || (state_nxt == ST_BREAK);
      if ((state == ST_RUN) && (state_nxt == ST_BREAK)) bp_hit <= 1'b1;
      else if (resume)                                  bp_hit <= 1'b0;
      if (resume)       bp_skip <= 1'b1;
      else if (core_en) bp_skip <= 1'b0;
    end
  end

  assign bus.o_core_en = core_en;
  assign bus.o_state   = state;
  assign bus.o_halted  = halted;
  assign bus.o_bp_hit  = bp_hit;

`ifdef CORE_RUN_CTRL_RETIRE_CNT_EN
  logic [31:0] retired_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                         retired_cnt <= 32'd0;
    else if (core_en && bus.i_insn_vld) retired_cnt <= retired_cnt + 32'd1;
  end

  assign bus.o_retired_cnt = retired_cnt;
`else
  logic unused_insn_vld;
  assign unused_insn_vld   = bus.i_insn_vld;
  assign bus.o_retired_cnt = 32'b0;
`endif

  // Word-aligned compare: the byte-offset bits take no part.
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.i_pc[1:0], bus.i_bp_addr[1:0]};

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl
//   Directed bench for core_run_ctrl. Four instances with different
//   parameters share one clock, each with its own reset:
//     dut_a: DIV_CNT=4, RUN_ON_RESET=1  free run, breakpoint, counter wrap
//     dut_b: DIV_CNT=4, RUN_ON_RESET=0  single step, request priority
//     dut_c: DIV_CNT=8, RUN_ON_RESET=0  reset in the middle of a step
//     dut_d: DIV_CNT=1, RUN_ON_RESET=1  tick every cycle
//   Inputs are driven 1 time unit after the rising edge and outputs are
//   sampled there as well.
module tb_core_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;
  logic rst_d = 1'b0;

  core_run_ctrl_if ifa ();
  core_run_ctrl_if ifb ();
  core_run_ctrl_if ifc ();
  core_run_ctrl_if ifd ();

  core_run_ctrl #(.DIV_CNT(32'd4), .RUN_ON_RESET(1'b1)) dut_a (.i_clk(clk), .i_reset(rst_a), .bus(ifa));
  core_run_ctrl #(.DIV_CNT(32'd4), .RUN_ON_RESET(1'b0)) dut_b (.i_clk(clk), .i_reset(rst_b), .bus(ifb));
  core_run_ctrl #(.DIV_CNT(32'd8), .RUN_ON_RESET(1'b0)) dut_c (.i_clk(clk), .i_reset(rst_c), .bus(ifc));
  core_run_ctrl #(.DIV_CNT(32'd1), .RUN_ON_RESET(1'b1)) dut_d (.i_clk(clk), .i_reset(rst_d), .bus(ifd));

`ifdef CORE_RUN_CTRL_RETIRE_CNT_EN
  localparam bit RCNT_EN = 1'b1;
`else
  localparam bit RCNT_EN = 1'b0;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // Expected retired count: the counter only exists when the macro is defined.
  function automatic logic [31:0] rexp(input logic [31:0] v);
    return RCNT_EN ? v : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_if_a();
    ifa.i_run_req = 0; ifa.i_halt_req = 0; ifa.i_step_req = 0; ifa.i_bp_en = 0;
    ifa.i_bp_addr = 0; ifa.i_pc = 0; ifa.i_insn_vld = 0;
  endtask

  initial begin
    int pulses;
    bit seen;
    clear_if_a();
    ifb.i_run_req = 0; ifb.i_halt_req = 0; ifb.i_step_req = 0; ifb.i_bp_en = 0;
    ifb.i_bp_addr = 0; ifb.i_pc = 0; ifb.i_insn_vld = 1;
    ifc.i_run_req = 0; ifc.i_halt_req = 0; ifc.i_step_req = 0; ifc.i_bp_en = 0;
    ifc.i_bp_addr = 0; ifc.i_pc = 0; ifc.i_insn_vld = 1;
    ifd.i_run_req = 0; ifd.i_halt_req = 0; ifd.i_step_req = 0; ifd.i_bp_en = 0;
    ifd.i_bp_addr = 0; ifd.i_pc = 0; ifd.i_insn_vld = 1;
    cyc(1);

    // ---------------- dut_a: free run ----------------
    ifa.i_insn_vld = 1;
    rst_a = 1;
    #1;
    chk("a_rst_core_en", ifa.o_core_en, 0);
    chk("a_rst_state",   ifa.o_state, 1);
    chk("a_rst_halted",  ifa.o_halted, 0);
    chk("a_rst_bp_hit",  ifa.o_bp_hit, 0);
    chk("a_rst_retired", ifa.o_retired_cnt, 0);
    cyc(2);
    chk("a_rst_core_en_held", ifa.o_core_en, 0);
    rst_a = 0;
    // commit enable is high in the cycle before edges 4, 8, 12
    for (int c = 1; c <= 12; c++) begin
      cyc(1);
      chk($sformatf("a_free_core_en_c%0d", c), ifa.o_core_en, (c % 4 == 3) ? 32'd1 : 32'd0);
    end
    chk("a_free_retired", ifa.o_retired_cnt, rexp(3));

    // ---------------- dut_a: breakpoint (low address bits ignored) ----------------
    ifa.i_bp_en = 1; ifa.i_bp_addr = 32'h13; ifa.i_pc = 32'h10;
    cyc(3);
    chk("a_bp_no_commit", ifa.o_core_en, 0);
    cyc(1);
    chk("a_bp_state",   ifa.o_state, 3);
    chk("a_bp_hit",     ifa.o_bp_hit, 1);
    chk("a_bp_halted",  ifa.o_halted, 1);
    chk("a_bp_core_en", ifa.o_core_en, 0);
    ifa.i_run_req = 1;
    cyc(1);
    ifa.i_run_req = 0;
    chk("a_resume_state",  ifa.o_state, 1);
    chk("a_resume_bp_hit", ifa.o_bp_hit, 0);
    chk("a_resume_halted", ifa.o_halted, 0);
    cyc(2);
    chk("a_resume_commit", ifa.o_core_en, 1);
    cyc(1);
    chk("a_resume_retired", ifa.o_retired_cnt, rexp(4));
    cyc(3);
    chk("a_retrap_no_commit", ifa.o_core_en, 0);
    cyc(1);
    chk("a_retrap_state", ifa.o_state, 3);

`ifdef CORE_RUN_CTRL_RETIRE_CNT_EN
    // ---------------- dut_a: retired counter wrap ----------------
    force dut_a.retired_cnt = 32'hFFFF_FFFF;
    #1;
    release dut_a.retired_cnt;
    ifa.i_pc = 32'h40;
    ifa.i_run_req = 1;
    cyc(1);
    ifa.i_run_req = 0;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      if (ifa.o_core_en) seen = 1;
      else cyc(1);
    end
    chk("a_wrap_commit_seen", {31'd0, seen}, 1);
    cyc(1);
    chk("a_wrap_retired", ifa.o_retired_cnt, 0);
`endif

    // ---------------- dut_b: single step ----------------
    rst_b = 1;
    #1;
    chk("b_rst_state",   ifb.o_state, 0);
    chk("b_rst_halted",  ifb.o_halted, 1);
    chk("b_rst_core_en", ifb.o_core_en, 0);
    cyc(1);
    rst_b = 0;
    ifb.i_step_req = 1;
    cyc(1);
    ifb.i_step_req = 0;
    chk("b_step_state",  ifb.o_state, 2);
    chk("b_step_halted", ifb.o_halted, 0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      if (ifb.o_core_en) pulses++;
      cyc(1);
    end
    chk("b_step_pulses",  pulses, 1);
    chk("b_step_state_after",  ifb.o_state, 0);
    chk("b_step_halted_after", ifb.o_halted, 1);
    chk("b_step_retired", ifb.o_retired_cnt, rexp(1));

    // ---------------- dut_b: request priority ----------------
    ifb.i_run_req = 1; ifb.i_step_req = 1; ifb.i_halt_req = 1;
    cyc(1);
    ifb.i_run_req = 0; ifb.i_step_req = 0; ifb.i_halt_req = 0;
    chk("b_prio_all_state", ifb.o_state, 0);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      if (ifb.o_core_en) pulses++;
      cyc(1);
    end
    ifb.i_run_req = 1; ifb.i_step_req = 1;
    cyc(1);
    ifb.i_run_req = 0; ifb.i_step_req = 0;
    chk("b_prio_step_run_state", ifb.o_state, 2);
    // abort the step before its tick arrives
    ifb.i_halt_req = 1;
    chk("b_abort_core_en", ifb.o_core_en, 0);
    cyc(1);
    ifb.i_halt_req = 0;
    chk("b_abort_state", ifb.o_state, 0);
    for (int k = 0; k < 8; k++) begin
      if (ifb.o_core_en) pulses++;
      cyc(1);
    end
    chk("b_prio_pulses",  pulses, 0);
    chk("b_prio_retired", ifb.o_retired_cnt, rexp(1));

    // ---------------- dut_c: reset during a step ----------------
    rst_c = 1;
    #1;
    cyc(1);
    rst_c = 0;
    ifc.i_step_req = 1;
    cyc(1);
    ifc.i_step_req = 0;
    chk("c_step_state", ifc.o_state, 2);
    pulses = 0;
    for (int k = 0; k < 2; k++) begin
      if (ifc.o_core_en) pulses++;
      cyc(1);
    end
    #2;
    rst_c = 1;
    #1;
    chk("c_midrst_state",   ifc.o_state, 0);
    chk("c_midrst_halted",  ifc.o_halted, 1);
    chk("c_midrst_core_en", ifc.o_core_en, 0);
    chk("c_midrst_bp_hit",  ifc.o_bp_hit, 0);
    chk("c_midrst_retired", ifc.o_retired_cnt, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      if (ifc.o_core_en) pulses++;
    end
    rst_c = 0;
    for (int k = 0; k < 20; k++) begin
      if (ifc.o_core_en) pulses++;
      cyc(1);
    end
    chk("c_midrst_pulses", pulses, 0);
    chk("c_after_state", ifc.o_state, 0);

    // ---------------- dut_d: DIV_CNT=1 ----------------
    rst_d = 1;
    #1;
    chk("d_rst_core_en", ifd.o_core_en, 0);
    cyc(1);
    rst_d = 0;
    #1;
    chk("d_core_en_c0", ifd.o_core_en, 1);
    for (int c = 1; c <= 3; c++) begin
      cyc(1);
      chk($sformatf("d_core_en_c%0d", c), ifd.o_core_en, 1);
    end
    chk("d_retired", ifd.o_retired_cnt, rexp(3));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
